// File: rtl/qpsk_bit_combiner.sv
// QPSK bit combiner: buffers (I,Q) pairs and re-serialises them at one bit per clock; first bit 1 cycle after write.
// Backpressure: sym_ready = !full (no write-through); optional status outputs under QPSK_BIT_COMBINER_STATUS_EN.
module qpsk_bit_combiner #(
   parameter int FIFO_DEPTH = 4,
   parameter bit I_FIRST    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sym_valid,
   input  logic sym_i,
   input  logic sym_q,
   output logic sym_ready,
   output logic data,
   output logic data_valid,
   output logic data_sel
`ifdef QPSK_BIT_COMBINER_STATUS_EN
   ,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  gap_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

   state_t        state, state_nxt;
   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [1:0]    head;
   logic          first_bit, second_bit;
   logic          hold, hold_nxt;
   logic          data_nxt, data_valid_nxt, data_sel_nxt;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign sym_ready = !rst && !full;
   assign push      = sym_valid && sym_ready;
   // Empty is judged on the registered count, so a same-edge push waits a cycle.
   assign pop       = ((state == IDLE) || (state == EMIT2)) && !empty;

   assign head       = mem[rd_ptr];
   assign first_bit  = I_FIRST ? head[1] : head[0];
   assign second_bit = I_FIRST ? head[0] : head[1];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {sym_i, sym_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= 1'b0;
         data       <= 1'b0;
         data_valid <= 1'b0;
         data_sel   <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold       <= hold_nxt;
         data       <= data_nxt;
         data_valid <= data_valid_nxt;
         data_sel   <= data_sel_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = empty ? IDLE : EMIT1;
         EMIT1:   state_nxt = EMIT2;
         EMIT2:   state_nxt = empty ? IDLE : EMIT1;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hold_nxt       = hold;
      data_nxt       = data;
      data_valid_nxt = data_valid;
      data_sel_nxt   = data_sel;
      case (state)
         IDLE, EMIT2: begin
            if (!empty) begin
               data_nxt       = first_bit;
               hold_nxt       = second_bit;
               data_sel_nxt   = !I_FIRST;
               data_valid_nxt = 1'b1;
            end else begin
               data_nxt       = 1'b0;
               data_sel_nxt   = 1'b0;
               data_valid_nxt = 1'b0;
            end
         end
         EMIT1: begin
            data_nxt       = hold;
            data_sel_nxt   = I_FIRST;
            data_valid_nxt = 1'b1;
         end
         default: begin
            data_nxt       = 1'b0;
            data_sel_nxt   = 1'b0;
            data_valid_nxt = 1'b0;
         end
      endcase
   end

`ifdef QPSK_BIT_COMBINER_STATUS_EN
   assign fifo_level = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt <= 8'd0;
      end else if ((state == EMIT2) && empty && (gap_cnt != 8'hFF)) begin
         gap_cnt <= gap_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/qpsk_bit_combiner.md
Name: qpsk_bit_combiner

Overview:
- Receive-side counterpart of the QPSK bit splitter.
- Accepts demodulated symbol bit pairs (I, Q) over a valid/ready handshake, buffers them in a small FIFO, and re-serialises them into a single bit stream at one bit per clock.
- Sits after the I/Q slicers and ahead of the serial data sink.

Parameters:
- FIFO_DEPTH, 4, symbol FIFO entries; power of 2, minimum 2.
- I_FIRST, 1, 1 = I bit emitted before Q bit; 0 = Q before I.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- sym_valid  in  1  symbol pair present on sym_i/sym_q
- sym_i  in  1  in-phase bit
- sym_q  in  1  quadrature bit
- sym_ready  out  1  FIFO can accept a symbol this cycle
- data  out  1  serial output bit
- data_valid  out  1  data carries a valid bit
- data_sel  out  1  0 = data is the I bit, 1 = data is the Q bit

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - FIFO empty, pointers 0.
  - FSM in IDLE.
  - data = 0, data_valid = 0, data_sel = 0.
  - sym_ready = 0 while rst is high; sym_ready = 1 on the first cycle after rst deasserts.
- Input handshake:
  - A symbol is written at a rising edge when sym_valid && sym_ready.
  - sym_ready = !full, combinational from the occupancy count.
  - When full, sym_ready is 0 even if a pop occurs in the same cycle (no write-through on full).
  - sym_i/sym_q are ignored when sym_valid = 0.
- FIFO:
  - FIFO_DEPTH x 2 bits, with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop on empty never occurs (the FSM guards it).
- Serializer FSM: states IDLE, EMIT1, EMIT2. All outputs are registered.
  - First bit = sym_i if I_FIRST = 1, else sym_q. Second bit is the other one.
  - IDLE, FIFO non-empty: pop; data <= first bit; hold <= second bit; data_sel <= !I_FIRST; data_valid <= 1; next state EMIT1.
  - IDLE, FIFO empty: stay in IDLE; data_valid = 0, data = 0.
  - EMIT1: data <= hold; data_sel <= I_FIRST; next state EMIT2. This transition is unconditional.
  - EMIT2, FIFO non-empty: pop and load exactly as in IDLE; next state EMIT1. No bubble between symbols.
  - EMIT2, FIFO empty: data_valid <= 0, data <= 0, data_sel <= 0; next state IDLE.
- Timing:
  - Latency: a symbol written at edge k into an empty FIFO with the FSM in IDLE gives its first bit valid after edge k+1 and its second bit after edge k+2.
  - Throughput: one bit per clock, i.e. one symbol per 2 clocks. Input may burst at one symbol per clock until the FIFO fills.
  - A push at the same edge the FSM checks for empty is not seen by that check; it is popped no earlier than the following edge.
- Reset mid-operation: any symbol in flight or buffered is discarded, and data_valid is 0 after the reset edge. No partial symbol is emitted afterwards.

Optional Feature:
- Macro: QPSK_BIT_COMBINER_STATUS_EN.
- Defined: adds two outputs.
  - fifo_level, log2(FIFO_DEPTH)+1 bits: the occupancy count. Reset value 0.
  - gap_cnt, 8 bits: increments on every EMIT2 -> IDLE transition (output stream gap) and saturates at 255. Reset value 0.
- Not defined: neither port exists, and no counter logic is synthesised.

Test Plan:
- Single symbol, I_FIRST = 1: push (i=1, q=0) at edge 1 -> after edge 2 data=1, data_sel=0, data_valid=1; after edge 3 data=0, data_sel=1; after edge 4 data_valid=0.
- Back-to-back stream: push 8 symbols with sym_valid held high, respecting sym_ready -> data_valid stays high for 16 consecutive cycles; bits appear in order I0,Q0,I1,Q1,...; sym_ready drops when 4 entries are buffered.
- Full FIFO plus pop: FIFO at 4 entries with the FSM popping -> sym_ready = 0 that cycle and the write is not taken; sym_ready = 1 the next cycle with count 3.
- I_FIRST = 0: push (i=1, q=0) -> emitted sequence is 0 then 1, with data_sel sequence 1 then 0.
- Reset mid-stream: assert rst during EMIT1 of the 2nd of 3 buffered symbols -> after the reset edge data_valid=0 and sym_ready=0; after deassert sym_ready=1 and no further bits are emitted without new input.
- With QPSK_BIT_COMBINER_STATUS_EN: two bursts of 2 symbols separated by 5 idle cycles -> gap_cnt = 2, fifo_level = 0 at end; 300 single-symbol bursts -> gap_cnt = 255.
